// File: rtl/wrr_arb_pkg.sv
// Shared types, default sizing and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_WEIGHT_W = 4;
  localparam int MAX_WIDTH    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Binary index of the set bit in a one-hot (or zero) vector; returns 0 for zero.
  function automatic int unsigned onehot_to_idx(input logic [MAX_WIDTH-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above pointer,
// wrapping to bit 0, found by priority-encoding a doubled, masked request vector.
module rr_pick #(
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic [WIDTH-1:0] request,
  input  logic [ID_W-1:0]  pointer,
  output logic [ID_W-1:0]  pick,
  output logic             pick_valid
);

  logic [WIDTH-1:0]   mask;
  logic [2*WIDTH-1:0] dbl;

  // Lower copy keeps only bits at/above pointer; upper copy supplies the wrap-around.
  assign mask = {WIDTH{1'b1}} << pointer;
  assign dbl  = {request, request & mask};

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and sets every output
    // first, so no path leaves a value held and no latch is inferred.
    pick       = '0;
    pick_valid = 1'b0;
    // Descending scan: the lowest set bit is written last and wins.
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      if (dbl[i]) begin
        pick       = ID_W'(i % WIDTH);
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a grantee keeps the resource for up to its weight
// in acked transactions, then the pointer rotates past it through one idle cycle.
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ID_W     = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic [WIDTH-1:0]          request,
  input  logic                      ack,
  input  logic                      cfg_load,
  input  logic [WIDTH*WEIGHT_W-1:0] weight_cfg,
  output logic [WIDTH-1:0]          grant,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);

  state_e              state, state_d;
  logic [ID_W-1:0]     pointer, pointer_d;
  logic [WEIGHT_W-1:0] credit, credit_d;
  logic [WIDTH-1:0]    grant_d;
  logic                grant_valid_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [WEIGHT_W-1:0] weight [WIDTH];

  logic [ID_W-1:0]     pick;
  logic                pick_valid;
  logic [WEIGHT_W-1:0] pick_weight;
  logic [WEIGHT_W-1:0] credit_dec;
  logic [ID_W-1:0]     pointer_next;

  rr_pick #(
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) u_pick (
    .request    (request),
    .pointer    (pointer),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // A programmed weight of zero still grants one transaction.
  assign pick_weight  = (weight[pick] == '0) ? WEIGHT_W'(1) : weight[pick];
  assign credit_dec   = credit - 1'b1;
  assign pointer_next = (grant_id == ID_W'(WIDTH-1)) ? '0 : grant_id + 1'b1;

  // NOTE: the weight bank is reset deliberately; every requester must start at
  // weight 1, so these are flops with a reset value, not an uninitialised RAM.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < WIDTH; i++) weight[i] <= WEIGHT_W'(1);
    end else if (cfg_load) begin
      for (int i = 0; i < WIDTH; i++) weight[i] <= weight_cfg[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_comb begin
    state_d       = state;
    pointer_d     = pointer;
    credit_d      = credit;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    grant_id_d    = grant_id;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d       = GRANT;
          grant_d       = WIDTH'(1) << pick;
          grant_valid_d = 1'b1;
          grant_id_d    = ID_W'(onehot_to_idx(MAX_WIDTH'(grant_d)));
          credit_d      = pick_weight;
        end
      end
      GRANT: begin
        if ((ack && (credit_dec == '0 || !request[grant_id])) ||
            (!ack && !request[grant_id])) begin
          // Turn over: completed its credit or abandoned; leftover credit is dropped.
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          credit_d      = '0;
          pointer_d     = pointer_next;
        end else if (ack) begin
          credit_d = credit_dec;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      pointer     <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_d;
      pointer     <= pointer_d;
      credit      <= credit_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
    end
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter that shares one downstream resource among WIDTH requesters. Each requester may hold the resource for up to its programmed weight consecutive transactions per turn before the pointer rotates. Grant is held until the resource returns ack, once per completed transaction. The block sits between the requester bank and the shared resource.

Parameters:
WIDTH, 4, number of requesters
WEIGHT_W, 4, bits per weight field; legal weights 1..2^WEIGHT_W-1
ID_W, $clog2(WIDTH), width of grant_id

Ports:
clk  input  1  system clock, all state on rising edge
resetb  input  1  asynchronous active-low reset
request  input  WIDTH  per-requester request, level, held until served
ack  input  1  resource completed one transaction for current grantee (1-cycle pulse)
cfg_load  input  1  latch weight_cfg into shadow weight registers
weight_cfg  input  WIDTH*WEIGHT_W  packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
grant  output  WIDTH  one-hot grant, all zero when idle
grant_valid  output  1  OR of grant
grant_id  output  ID_W  binary index of grantee, 0 when idle

Behaviour:
- One clock (clk); reset is asynchronous and active-low (resetb). Assertion immediately clears grant, grant_valid, grant_id to 0; state IDLE; pointer 0; credit 0; all weights 1.
- FSM states: IDLE, GRANT.
- IDLE: if request != 0, pick first requester with request set, searching from pointer upward, wrapping WIDTH-1 -> 0. Next edge: state GRANT, grant = one-hot(pick), credit = weight[pick]. If request == 0, stay IDLE, outputs 0.
- Latency: request rising in IDLE at cycle N -> grant at N+1.
- GRANT, ack=1:
  - credit decrements.
  - If new credit > 0 and request[grantee] still 1, hold grant (back-to-back, no bubble).
  - Otherwise drop grant next cycle, pointer = grantee+1 mod WIDTH, return to IDLE.
- GRANT, ack=0, request[grantee]=1: hold grant, no change.
- GRANT, ack=0, request[grantee]=0 (abandon): drop grant next cycle, pointer = grantee+1, IDLE. Credit is discarded.
- ack while in IDLE: ignored.
- Rotation always costs exactly one idle cycle (grant=0) between different grantees.
- Weights:
  - A weight field of 0 is treated as 1.
  - cfg_load is accepted any cycle. New weights apply only at the next credit load; the current turn's credit is unaffected.
- Fairness bound: a continuously asserting requester waits at most sum over other requesters of (weight+1) cycles-per-transaction turns.
- grant is always one-hot or zero. Never more than one bit set.
- grant_id and grant_valid are registered together with grant, with no combinational path from inputs to outputs.

Decomposition:
- Package wrr_arb_pkg:
  - FSM state enum (IDLE, GRANT).
  - Default WIDTH/WEIGHT_W constants.
  - Function for one-hot to index.
- Sub-module rr_pick: combinational rotating priority picker.
  - Inputs: request, pointer.
  - Outputs: pick index, pick valid.
  - Implemented by double-width mask-and-priority.
- wrr_arbiter holds the FSM, credit counter, pointer and weight registers.

Test Plan:
- Reset/idle: resetb=0 for 5 cycles with request=4'b1010 -> grant=0, grant_valid=0. Release with weights default 1 -> grant=4'b0010 one cycle later. ack -> idle cycle, then grant=4'b1000. ack -> idle, then grant=4'b0010.
- Weights: cfg_load with weights {r3=1,r2=1,r1=1,r0=3}, request=4'b0111, ack every cycle while granted.
  - Required pattern: r0,r0,r0,idle,r1,idle,r2,idle,r0,r0,r0.
  - grant_id follows 0,1,2 accordingly.
- Single requester: request=4'b1000, ack every grant cycle, weight 2.
  - Required: grant=4'b1000 for 2 cycles, 1 idle cycle, re-granted 4'b1000; repeats with no starvation of itself.
- Abandon: r2 granted, request[2] drops with ack=0, request=4'b0001 still high.
  - Required: grant drops next cycle; the next grant goes to r0, since pointer=3 wraps to 0.
- Mid-operation reset: assert resetb=0 asynchronously mid-cycle while grant=4'b0100.
  - Required: grant=0 before the next clk edge.
  - After release, pointer restarts at 0; with request=4'b0101, the first grant is 4'b0001.
- Weight 0 / late cfg_load:
  - Program r1 weight 0 -> behaves as 1.
  - cfg_load during an r0 turn changing r0 to 1 -> the current turn completes its old credit, and the new weight applies from the next r0 turn.
